oem_sort_pipe: RTL
==================

# oem_sort_pipe

Parametrised, fully pipelined Batcher odd-even merge sorter for N_INPUTS = 2^LOG2_N lanes of DATA_WIDTH bits. It is the generalised successor of the fixed 8-lane odd-even network in the MDSA datapath. It adds:
- valid/ready flow control
- per-batch sort direction carried down the pipeline
- a signed/unsigned compare mode
- a per-batch sideband tag
- an in-flight occupancy counter

It sits between the row/column buffers and the MDSA merge stages, so batches of either direction can stream back-to-back.

## Interface
Parameters:
- DATA_WIDTH, 32, bits per lane
- LOG2_N, 3, log2 of lane count; N_INPUTS = 2^LOG2_N; legal values are 1..5
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare
- TAG_WIDTH, 4, sideband bits carried unmodified with each batch

Ports:
- clk, input, 1, clock; all state updates on the rising edge
- rst, input, 1, asynchronous, active-high reset
- en, input, 1, global clock enable; 0 freezes all state
- in_valid, input, 1, input batch is present
- in_ready, output, 1, sorter accepts a batch this cycle
- direction, input, 1, 0 = ascending, 1 = descending; sampled with the batch
- in_tag, input, TAG_WIDTH, sideband for the batch
- data_in, input, N_INPUTS*DATA_WIDTH, lane k = data_in[k*DATA_WIDTH +: DATA_WIDTH]
- out_valid, output, 1, a sorted batch is present
- out_ready, input, 1, downstream accepts the batch
- out_dir, output, 1, the direction the output batch was sorted with
- out_tag, output, TAG_WIDTH, the sideband of the output batch
- data_out, output, N_INPUTS*DATA_WIDTH, sorted lanes, same lane packing as data_in
- occupancy, output, clog2(S+1), number of valid batches in the pipe

## Operation
- Stage count S = LOG2_N*(LOG2_N+1)/2. N=8 gives 6 stages; N=16 gives 10; N=32 gives 15.
- Network: standard Batcher odd-even merge sort. Enumerate stages in this order: for p = 1,2,4..N/2, for k = p,p/2..1, one stage.
  - Within a stage, compare the pair (i+j, i+j+k) for j = k mod p, stepping by 2k while j < N-k, and i = 0..k-1.
  - A pair is only compared when floor((i+j)/2p) == floor((i+j+k)/2p).
  - Lanes that are not compared pass through the stage register unchanged.
- Compare-and-swap on a pair (lo, hi):
  - When the batch's dir = 0: lo gets min, hi gets max.
  - When dir = 1: lo gets max, hi gets min.
  - Ties never swap.
  - The compare is signed when SIGNED = 1 and unsigned otherwise.
- Every stage registers its data lanes together with the batch's valid, dir and tag. The direction used by each comparator is the dir registered alongside that batch, never the live `direction` port.
- Advance: adv = en & (~out_valid | out_ready).
  - When adv = 1, every stage loads from its predecessor. Stage 0 loads data_in, direction, in_tag and in_valid.
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
- in_ready = adv. This is combinational from en, out_ready and out_valid.
- A batch is accepted when in_valid & in_ready. A batch is delivered when out_valid & out_ready.
- occupancy:
  - increments on accept without a delivery
  - decrements on delivery without an accept
  - is unchanged when both or neither occur
  - never exceeds S
- data_out, out_dir, out_tag and out_valid come directly from the final stage register.

## Timing
- Reset (rst asserted, asynchronous): all stage valid bits, data, dir and tag registers are 0. Therefore out_valid = 0, data_out = 0, out_dir = 0, out_tag = 0, occupancy = 0. While reset is held, in_ready = en.
- Reset asserted mid-stream discards every in-flight batch. No partial batch emerges after reset is released.
- Latency: with adv held at 1, a batch accepted at edge t has out_valid = 1 after edge t+S-1.
- Throughput: one batch per cycle when out_ready = 1 and en = 1.
- Stall: when out_valid = 1 and out_ready = 0, the entire pipe holds. While stalled, data_out, out_dir and out_tag remain stable and in_ready = 0.
- en = 0 holds all state. in_ready = 0. out_valid keeps its value.
- A batch with in_valid = 0 inserts a bubble: its valid bit is 0 and its data still propagates, but its data is don't-care.
- Back-to-back batches with opposite direction are each sorted by their own dir, with no dead cycle between them.

## Test plan
- Ascending sort, N=8, DATA_WIDTH=8, SIGNED=0. Lanes 0..7 = {5,3,7,1,8,2,6,4}, dir=0, tag=0xA → out_valid rises S=6 cycles later with lanes {1,2,3,4,5,6,7,8}, out_dir=0, out_tag=0xA.
- Alternating direction, back-to-back. Same data with dir = 0,1,0 on consecutive cycles → three consecutive outputs: {1..8}, then {8,7,6,5,4,3,2,1}, then {1..8}, with no gap between them.
- Signed mode, SIGNED=1, lanes {0x80,0x7F,0xFF,0x00,0x01,0xFE,0x10,0x80}, dir=0 → {0x80,0x80,0xFE,0xFF,0x00,0x01,0x10,0x7F}. With SIGNED=0 the same input gives {0x00,0x01,0x10,0x7F,0x80,0x80,0xFE,0xFF}.
- Backpressure. Stream 10 random batches with out_ready low for 3 cycles mid-stream →
  - in_ready = 0 throughout the stall
  - data_out held stable
  - occupancy never exceeds 6
  - every batch delivered exactly once, in order, and matching a software sort
- Reset mid-stream. Assert rst with occupancy = 4 → out_valid = 0, data_out = 0 and occupancy = 0 immediately. After release, no stale batch appears and a new batch emerges after 6 cycles.
- Parameter sweep: LOG2_N = 1, 4 and 5, with DATA_WIDTH = 16 and all-equal or duplicate-heavy inputs. Output is sorted, tags are preserved, and the latencies are 1, 10 and 15 respectively.

Source files
------------

// File: rtl/oem_sort_pipe.sv
`default_nettype none
// ============================================================================
// oem_sort_pipe : pipelined Batcher odd-even merge sorter, valid/ready flow,
//                 per-batch direction and tag, in-flight occupancy.  Rev 1.0
// ============================================================================
module oem_sort_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_N     = 3,
  parameter int SIGNED     = 0,
  parameter int TAG_WIDTH  = 4,
  localparam int N_INPUTS  = 1 << LOG2_N,
  localparam int STAGES    = LOG2_N * (LOG2_N + 1) / 2,
  localparam int OCC_W     = $clog2(STAGES + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           direction,
  input  logic [TAG_WIDTH-1:0]           in_tag,
  input  logic [N_INPUTS*DATA_WIDTH-1:0] data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_dir,
  output logic [TAG_WIDTH-1:0]           out_tag,
  output logic [N_INPUTS*DATA_WIDTH-1:0] data_out,
  output logic [OCC_W-1:0]               occupancy
);

  // Role of lane m in the stage (p, k): 0 = pass, 64+partner = lo, 128+partner = hi.
  function automatic int pair_code(input int p, input int k, input int m);
    int code;
    code = 0;
    for (int j = k % p; j < N_INPUTS - k; j += 2 * k) begin
      for (int i = 0; i < k; i++) begin
        if (((i + j) / (2 * p) == (i + j + k) / (2 * p)) && (i + j + k < N_INPUTS)) begin
          if (m == i + j)          code = 64 + (i + j + k);
          else if (m == i + j + k) code = 128 + (i + j);
        end
      end
    end
    return code;
  endfunction

  function automatic logic gt(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    return a > b;
  endfunction

  logic [DATA_WIDTH-1:0] r_data [STAGES][N_INPUTS];
  logic [DATA_WIDTH-1:0] w_next [STAGES][N_INPUTS];
  logic [TAG_WIDTH-1:0]  r_tag  [STAGES];
  logic [STAGES-1:0]     r_valid;
  logic [STAGES-1:0]     r_dir;
  logic [OCC_W-1:0]      r_occ;
  logic                  w_adv;
  logic                  w_accept;
  logic                  w_deliver;

  assign w_adv     = en & (~out_valid | out_ready);
  assign w_accept  = in_valid & w_adv;
  assign w_deliver = out_valid & w_adv;

  for (genvar gp = 0; gp < LOG2_N; gp++) begin : g_merge
    for (genvar gk = 0; gk <= gp; gk++) begin : g_stage
      localparam int P     = 1 << gp;
      localparam int K     = 1 << (gp - gk);
      localparam int S_IDX = gp * (gp + 1) / 2 + gk;

      logic [DATA_WIDTH-1:0] w_src [N_INPUTS];
      logic                  w_dir;
      logic [N_INPUTS-1:0]   w_swap;

      // Stage 0 sorts straight off the input bus using the direction sampled with it.
      if (S_IDX == 0) begin : g_src_in
        for (genvar m = 0; m < N_INPUTS; m++) begin : g_lane
          assign w_src[m] = data_in[m*DATA_WIDTH +: DATA_WIDTH];
        end
        assign w_dir = direction;
      end else begin : g_src_reg
        for (genvar m = 0; m < N_INPUTS; m++) begin : g_lane
          assign w_src[m] = r_data[S_IDX-1][m];
        end
        assign w_dir = r_dir[S_IDX-1];
      end

      for (genvar m = 0; m < N_INPUTS; m++) begin : g_lane
        localparam int CODE = pair_code(P, K, m);
        if (CODE >= 128) begin : g_hi
          assign w_swap[m] = 1'b0;
          assign w_next[S_IDX][m] = w_swap[CODE % 64] ? w_src[CODE % 64] : w_src[m];
        end else if (CODE >= 64) begin : g_lo
          // Strict compares keep equal keys in place.
          assign w_swap[m] = w_dir ? gt(w_src[CODE % 64], w_src[m])
                                   : gt(w_src[m], w_src[CODE % 64]);
          assign w_next[S_IDX][m] = w_swap[m] ? w_src[CODE % 64] : w_src[m];
        end else begin : g_pass
          assign w_swap[m] = 1'b0;
          assign w_next[S_IDX][m] = w_src[m];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int m = 0; m < N_INPUTS; m++) r_data[s][m] <= '0;
        r_tag[s] <= '0;
      end
      r_valid <= '0;
      r_dir   <= '0;
      r_occ   <= '0;
    end else if (w_adv) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int m = 0; m < N_INPUTS; m++) r_data[s][m] <= w_next[s][m];
      end
      r_valid[0] <= in_valid;
      r_dir[0]   <= direction;
      r_tag[0]   <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_dir[s]   <= r_dir[s-1];
        r_tag[s]   <= r_tag[s-1];
      end
      if (w_accept && !w_deliver)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_accept && w_deliver) r_occ <= r_occ - OCC_W'(1);
    end
  end

  for (genvar m = 0; m < N_INPUTS; m++) begin : g_out
    assign data_out[m*DATA_WIDTH +: DATA_WIDTH] = r_data[STAGES-1][m];
  end

  assign in_ready  = w_adv;
  assign out_valid = r_valid[STAGES-1];
  assign out_dir   = r_dir[STAGES-1];
  assign out_tag   = r_tag[STAGES-1];
  assign occupancy = r_occ;

endmodule
`default_nettype wire
